// File: rtl/pin_entry_if.sv
// Keypad, authenticator and status signals of the PIN entry controller.
interface pin_entry_if;
    logic        start;
    logic        cancel;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_enter;
    logic        key_clear;
    logic        acc_found_stat;
    logic        acc_auth_stat;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        busy;
    logic        auth_done;
    logic        auth_ok;
    logic        entry_err;
    logic        timeout;
    logic        locked;
    logic [1:0]  attempts_left;

    // Controller side
    modport slave (
        input  start, cancel, key_valid, key_digit, key_enter, key_clear,
               acc_found_stat, acc_auth_stat,
        output acc_num, pin, busy, auth_done, auth_ok, entry_err, timeout, locked,
               attempts_left
    );

    // Keypad/authenticator side
    modport master (
        output start, cancel, key_valid, key_digit, key_enter, key_clear,
               acc_found_stat, acc_auth_stat,
        input  acc_num, pin, busy, auth_done, auth_ok, entry_err, timeout, locked,
               attempts_left
    );
endinterface

// File: rtl/pin_entry_controller.sv
// Collects account number and PIN from the keypad, checks them against the
// authenticator, and enforces retry limit, lockout and inactivity timeout.
module pin_entry_controller #(
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned PIN_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    pin_entry_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle, StGetAcc, StGetPin, StCheck, StDoneOk, StLocked
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  acc_num_q, acc_num_d;
    logic [15:0] pin_q, pin_d;
    logic [1:0]  attempts_q, attempts_d;
    logic [15:0] timer_q, timer_d;
    logic        auth_done_q, auth_done_d;
    logic        entry_err_q, entry_err_d;
    logic        timeout_q, timeout_d;

    logic        key_any;
    logic        digit_ok;
    logic        timer_end;
    logic [6:0]  acc_ext;
    logic [4:0]  acc_sat;
    logic [15:0] pin_ext;

    assign key_any   = bus.key_valid | bus.key_enter | bus.key_clear;
    assign digit_ok  = bus.key_valid && (bus.key_digit <= 4'd9);
    assign timer_end = (timer_q == 16'(TIMEOUT_CYCLES - 1));
    assign acc_ext   = 7'(acc_q) * 7'd10 + 7'(bus.key_digit);
    // Saturate so an oversized two-digit account can never wrap into 1..15
    assign acc_sat   = (acc_ext > 7'd31) ? 5'd31 : acc_ext[4:0];
    assign pin_ext   = pin_q * 16'd10 + 16'(bus.key_digit);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_num_d   = acc_num_q;
        pin_d       = pin_q;
        attempts_d  = attempts_q;
        auth_done_d = 1'b0;
        entry_err_d = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StGetAcc;
                    acc_d      = '0;
                    cnt_d      = '0;
                    acc_num_d  = '0;
                    pin_d      = '0;
                    attempts_d = 2'(MAX_ATTEMPTS);
                end
            end
            StGetAcc: begin
                if (bus.key_clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (bus.key_enter) begin
                    if (cnt_q != 3'd0 && acc_q >= 5'd1 && acc_q <= 5'd15) begin
                        acc_num_d = acc_q[3:0];
                        pin_d     = '0;
                        cnt_d     = '0;
                        state_d   = StGetPin;
                    end else begin
                        entry_err_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end
                end else if (digit_ok) begin
                    if (cnt_q < 3'd2) begin
                        acc_d = acc_sat;
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (!key_any && timer_end) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StGetPin: begin
                if (bus.key_clear) begin
                    pin_d = '0;
                    cnt_d = '0;
                end else if (bus.key_enter) begin
                    if (cnt_q == 3'(PIN_DIGITS)) begin
                        state_d = StCheck;
                    end else begin
                        entry_err_d = 1'b1;
                        pin_d       = '0;
                        cnt_d       = '0;
                    end
                end else if (digit_ok) begin
                    if (cnt_q < 3'(PIN_DIGITS)) begin
                        pin_d = pin_ext;
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (!key_any && timer_end) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StCheck: begin
                auth_done_d = 1'b1;
                if (!bus.acc_found_stat) begin
                    state_d     = StGetAcc;
                    entry_err_d = 1'b1;
                    acc_num_d   = '0;
                    pin_d       = '0;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else if (bus.acc_auth_stat) begin
                    state_d = StDoneOk;
                end else if (attempts_q > 2'd1) begin
                    state_d     = StGetPin;
                    entry_err_d = 1'b1;
                    attempts_d  = attempts_q - 2'd1;
                    pin_d       = '0;
                    cnt_d       = '0;
                end else begin
                    state_d     = StLocked;
                    entry_err_d = 1'b1;
                    attempts_d  = '0;
                end
            end
            default: ;
        endcase

        // Timeout aborts share the cancel clears
        if (timeout_d) begin
            acc_num_d = '0;
            pin_d     = '0;
            acc_d     = '0;
            cnt_d     = '0;
        end

        // Cancel overrides everything except lockout
        if (bus.cancel && state_q != StLocked) begin
            state_d     = StIdle;
            acc_num_d   = '0;
            pin_d       = '0;
            acc_d       = '0;
            cnt_d       = '0;
            auth_done_d = 1'b0;
            entry_err_d = 1'b0;
            timeout_d   = 1'b0;
        end

        // Inactivity timer runs only while waiting for keys in an entry state
        if (state_d != state_q || key_any ||
            !(state_q == StGetAcc || state_q == StGetPin)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 16'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_num_q   <= '0;
            pin_q       <= '0;
            attempts_q  <= 2'(MAX_ATTEMPTS);
            timer_q     <= '0;
            auth_done_q <= 1'b0;
            entry_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_num_q   <= acc_num_d;
            pin_q       <= pin_d;
            attempts_q  <= attempts_d;
            timer_q     <= timer_d;
            auth_done_q <= auth_done_d;
            entry_err_q <= entry_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.acc_num       = acc_num_q;
    assign bus.pin           = pin_q;
    assign bus.busy          = (state_q == StGetAcc) || (state_q == StGetPin) ||
                               (state_q == StCheck);
    assign bus.auth_done     = auth_done_q;
    assign bus.auth_ok       = (state_q == StDoneOk);
    assign bus.entry_err     = entry_err_q;
    assign bus.timeout       = timeout_q;
    assign bus.locked        = (state_q == StLocked);
    assign bus.attempts_left = attempts_q;

endmodule
